// File: rtl/mips_mem_responder_if.sv
// CPU-side bus of the unified instruction/data memory responder: fetch port,
// data port, preload port and status outputs.
interface mips_mem_responder_if;
    logic [31:0] instr_addr;
    logic [31:0] instr_out;
    logic        data_en;
    logic        data_rd_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        err_clear;
    logic        err_misaligned;
    logic        err_range;
    logic [31:0] wr_count;

    modport master (
        output instr_addr, data_en, data_rd_wr, data_addr, data_wdata,
               load_en, load_addr, load_data, err_clear,
        input  instr_out, data_rdata, err_misaligned, err_range, wr_count
    );

    modport slave (
        input  instr_addr, data_en, data_rd_wr, data_addr, data_wdata,
               load_en, load_addr, load_data, err_clear,
        output instr_out, data_rdata, err_misaligned, err_range, wr_count
    );
endinterface

// File: rtl/mips_mem_responder.sv
// Unified word memory serving one fetch and one data access per cycle with
// 1-cycle registered reads, write-first forwarding, preload and sticky errors.
module mips_mem_responder #(
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS    = 524288,
    parameter logic [31:0] INSTR_OOR_DATA = 32'h0000_0000,
    parameter logic [31:0] DATA_OOR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mips_mem_responder_if.slave   bus
);
    localparam int          IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

    typedef logic [IDX_W-1:0] idx_t;

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> 2) < DEPTH_U);
    endfunction

    function automatic idx_t to_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return idx_t'(off >> 2);
    endfunction

    logic [31:0] mem [0:DEPTH_WORDS-1];

    logic [31:0] instr_q, instr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_mis_q, err_mis_d;
    logic        err_rng_q, err_rng_d;
    logic [31:0] wr_count_q, wr_count_d;

    logic        f_ok, d_ok, d_mis, l_ok, cpu_wr, we;
    idx_t        f_idx, d_idx, l_idx, w_idx;
    logic [31:0] w_data;
    logic        set_mis, set_rng;

    always_comb begin
        f_ok   = in_range(bus.instr_addr);
        f_idx  = to_idx(bus.instr_addr);
        d_ok   = in_range(bus.data_addr);
        d_idx  = to_idx(bus.data_addr);
        d_mis  = (bus.data_addr[1:0] != 2'b00);
        l_idx  = to_idx(bus.load_addr);
        l_ok   = bus.load_en && in_range(bus.load_addr) && (bus.load_addr[1:0] == 2'b00);
        // Any preload strobe owns the write port, even if the preload itself is dropped.
        cpu_wr = bus.data_en && !bus.data_rd_wr && d_ok && !d_mis && !bus.load_en;
        we     = l_ok || cpu_wr;
        w_idx  = l_ok ? l_idx : d_idx;
        w_data = l_ok ? bus.load_data : bus.data_wdata;

        instr_d = INSTR_OOR_DATA;
        if (f_ok) begin
            instr_d = (we && (w_idx == f_idx)) ? w_data : mem[f_idx];
        end

        rdata_d = rdata_q;
        if (bus.data_en && bus.data_rd_wr) begin
            if (!d_ok) begin
                rdata_d = DATA_OOR_DATA;
            end else begin
                rdata_d = (we && (w_idx == d_idx)) ? w_data : mem[d_idx];
            end
        end

        set_mis   = (bus.instr_addr[1:0] != 2'b00) || (bus.data_en && d_mis);
        set_rng   = !f_ok || (bus.data_en && !d_ok);
        err_mis_d = set_mis || (err_mis_q && !bus.err_clear);
        err_rng_d = set_rng || (err_rng_q && !bus.err_clear);

        wr_count_d = wr_count_q + {31'd0, cpu_wr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= '0;
            rdata_q    <= '0;
            err_mis_q  <= 1'b0;
            err_rng_q  <= 1'b0;
            wr_count_q <= '0;
        end else begin
            instr_q    <= instr_d;
            rdata_q    <= rdata_d;
            err_mis_q  <= err_mis_d;
            err_rng_q  <= err_rng_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Array has no reset, but a write is suppressed while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (we) begin
            mem[w_idx] <= w_data;
        end
    end

    assign bus.instr_out      = instr_q;
    assign bus.data_rdata     = rdata_q;
    assign bus.err_misaligned = err_mis_q;
    assign bus.err_range      = err_rng_q;
    assign bus.wr_count       = wr_count_q;
endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomized bench for mips_mem_responder against a word-map reference model,
// preceded by directed boot, store/load, forwarding, error and priority cases.
module tb_mips_mem_responder;
    localparam logic [31:0]    BASE  = 32'h8000_0000;
    localparam longint unsigned DEPTH = 524288;
    localparam logic [31:0]    W0 = 32'h8002_0000;
    localparam logic [31:0]    W1 = 32'h8011_FFC0;
    localparam logic [31:0]    W2 = 32'h801F_FFC0;
    localparam logic [31:0]    WINS [3] = '{W0, W1, W2};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mips_mem_responder_if bus();

    mips_mem_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mdl [int];
    logic [31:0] m_instr, m_rdata, m_wrc;
    logic        m_mis, m_rng;
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic bit inr(input logic [31:0] a);
        longint unsigned x;
        x = 64'(a);
        return (x >= 64'(BASE)) && (x < 64'(BASE) + 4 * DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        int k;
        a = WINS[$urandom_range(0, 2)] + 32'($urandom_range(0, 15)) * 32'd4;
        k = $urandom_range(0, 19);
        case (k)
            0: a = 32'h7FFF_FFFC;
            1: a = 32'h8020_0000;
            2: a = 32'hFFFF_FFFC;
            3: a = 32'h0000_0000;
            4: a = a + 32'($urandom_range(1, 3));
            default: ;
        endcase
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".instr_out"},  bus.instr_out,             m_instr);
        chk({tag, ".data_rdata"}, bus.data_rdata,            m_rdata);
        chk({tag, ".err_mis"},    {31'd0, bus.err_misaligned}, {31'd0, m_mis});
        chk({tag, ".err_rng"},    {31'd0, bus.err_range},    {31'd0, m_rng});
        chk({tag, ".wr_count"},   bus.wr_count,              m_wrc);
    endtask

    // One clock: apply the rules to the model (writes land first), then compare.
    task automatic cycle(input string tag);
        bit wl, wc, rd, sm, sr;
        logic [31:0] ia, da;
        ia = bus.instr_addr;
        da = bus.data_addr;
        wl = bus.load_en && inr(bus.load_addr) && (bus.load_addr[1:0] == 2'b00);
        wc = bus.data_en && !bus.data_rd_wr && !bus.load_en && inr(da) && (da[1:0] == 2'b00);
        rd = bus.data_en && bus.data_rd_wr;
        sm = (ia[1:0] != 2'b00) || (bus.data_en && (da[1:0] != 2'b00));
        sr = !inr(ia) || (bus.data_en && !inr(da));
        if (wl) mdl[widx(bus.load_addr)] = bus.load_data;
        if (wc) begin
            mdl[widx(da)] = bus.data_wdata;
            m_wrc = m_wrc + 32'd1;
        end
        m_instr = inr(ia) ? mdl[widx(ia)] : 32'h0000_0000;
        if (rd) m_rdata = inr(da) ? mdl[widx(da)] : 32'hDEAD_BEEF;
        m_mis = sm || (m_mis && !bus.err_clear);
        m_rng = sr || (m_rng && !bus.err_clear);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        bus.data_en   = 1'b0;
        bus.load_en   = 1'b0;
        bus.err_clear = 1'b0;
        bus.instr_addr = W0;
    endtask

    task automatic model_reset();
        m_instr = '0; m_rdata = '0; m_wrc = '0; m_mis = 1'b0; m_rng = 1'b0;
    endtask

    initial begin
        bus.instr_addr = W0;   bus.data_en = 1'b0; bus.data_rd_wr = 1'b1;
        bus.data_addr  = W0;   bus.data_wdata = '0;
        bus.load_en    = 1'b0; bus.load_addr = W0; bus.load_data = '0;
        bus.err_clear  = 1'b0;
        model_reset();

        #2 rst_n = 1'b0;
        #1 check_all("reset");
        @(posedge clk);
        #1;
        bus.load_en = 1'b1;
        rst_n = 1'b1;

        // Fill three windows (fetching each word as it is written).
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 16; i++) begin
                bus.load_addr  = WINS[w] + 32'(i) * 32'd4;
                bus.load_data  = $urandom;
                bus.instr_addr = bus.load_addr;
                cycle("preload");
            end
        end
        bus.load_addr = 32'h8010_0000; bus.load_data = 32'h0BAD_F00D;
        bus.instr_addr = 32'h8010_0000;
        cycle("preload_x");
        bus.instr_addr = W0;
        bus.load_addr = W0;          bus.load_data = 32'h27BD_FFF8; cycle("boot0");
        bus.load_addr = W0 + 32'd4;  bus.load_data = 32'h03E0_0008; cycle("boot1");
        idle();
        bus.instr_addr = W0;         cycle("fetch0");
        chk("fetch0_word", bus.instr_out, 32'h27BD_FFF8);
        bus.instr_addr = W0 + 32'd4; cycle("fetch1");
        chk("fetch1_word", bus.instr_out, 32'h03E0_0008);

        // Store then load.
        bus.instr_addr = W0;
        bus.data_en = 1'b1; bus.data_rd_wr = 1'b0;
        bus.data_addr = 32'h8011_FFF8; bus.data_wdata = 32'h1234_5678;
        cycle("store");
        bus.data_rd_wr = 1'b1;
        cycle("load");
        chk("load_word", bus.data_rdata, 32'h1234_5678);
        chk("load_wrcnt", bus.wr_count, 32'd1);

        // Write-first forwarding from preload to both read ports.
        bus.load_en = 1'b1; bus.load_addr = 32'h8002_0008; bus.load_data = 32'hCAFE_F00D;
        bus.instr_addr = 32'h8002_0008;
        bus.data_en = 1'b1; bus.data_rd_wr = 1'b1; bus.data_addr = 32'h8002_0008;
        cycle("fwd_load");
        chk("fwd_instr", bus.instr_out, 32'hCAFE_F00D);
        chk("fwd_rdata", bus.data_rdata, 32'hCAFE_F00D);
        bus.load_en = 1'b0;
        bus.data_rd_wr = 1'b0; bus.data_wdata = 32'h1357_9BDF;
        cycle("fwd_cpu");
        chk("fwd_cpu_instr", bus.instr_out, 32'h1357_9BDF);

        // Range and alignment errors.
        idle();
        bus.data_en = 1'b1; bus.data_rd_wr = 1'b1; bus.data_addr = 32'h7FFF_FFFC;
        cycle("oor_read");
        chk("oor_rdata", bus.data_rdata, 32'hDEAD_BEEF);
        chk("oor_rd_flag", {31'd0, bus.err_range}, 32'd1);
        idle(); bus.err_clear = 1'b1; cycle("clear1");
        chk("clear_flag", {31'd0, bus.err_range}, 32'd0);
        idle(); bus.instr_addr = 32'h8020_0000; cycle("oor_fetch");
        chk("oor_instr", bus.instr_out, 32'h0);
        chk("oor_f_flag", {31'd0, bus.err_range}, 32'd1);
        idle(); bus.err_clear = 1'b1; cycle("clear2");
        idle();
        bus.data_en = 1'b1; bus.data_rd_wr = 1'b0;
        bus.data_addr = 32'h8010_0002; bus.data_wdata = 32'hFFFF_0000;
        cycle("mis_write");
        chk("mis_flag", {31'd0, bus.err_misaligned}, 32'd1);
        chk("mis_wrcnt", bus.wr_count, 32'd2);
        bus.data_rd_wr = 1'b1; bus.data_addr = 32'h8010_0000;
        cycle("mis_readback");
        chk("mis_unchanged", bus.data_rdata, 32'h0BAD_F00D);
        bus.err_clear = 1'b1; bus.data_addr = 32'h8010_0002;
        cycle("clear_vs_set");
        chk("set_wins", {31'd0, bus.err_misaligned}, 32'd1);

        // Mid-run reset; a write held across the edge must not commit.
        idle();
        bus.data_en = 1'b1; bus.data_rd_wr = 1'b0; bus.data_addr = W0; bus.data_wdata = 32'hFFFF_FFFF;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midreset");
        @(posedge clk);
        #1;
        chk("reset_hold_wrcnt", bus.wr_count, 32'd0);
        idle();
        bus.data_en = 1'b1; bus.data_rd_wr = 1'b1; bus.data_addr = W0;
        rst_n = 1'b1;
        cycle("post_reset");
        chk("post_reset_mem", bus.data_rdata, 32'h27BD_FFF8);

        // Preload takes the write port from a simultaneous CPU write.
        idle();
        bus.load_en = 1'b1; bus.load_addr = W0 + 32'h10; bus.load_data = 32'hA5A5_0001;
        bus.data_en = 1'b1; bus.data_rd_wr = 1'b0;
        bus.data_addr = W0 + 32'h14; bus.data_wdata = 32'h5A5A_0002;
        cycle("prio");
        bus.load_en = 1'b0; bus.data_rd_wr = 1'b1;
        cycle("prio_cpu_word");
        chk("prio_wrcnt", bus.wr_count, 32'd0);
        bus.data_addr = W0 + 32'h10;
        cycle("prio_load_word");
        chk("prio_load", bus.data_rdata, 32'hA5A5_0001);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            bus.instr_addr = rnd_addr();
            bus.data_en    = ($urandom_range(0, 3) != 0);
            bus.data_rd_wr = $urandom_range(0, 1) != 0;
            bus.data_addr  = rnd_addr();
            bus.data_wdata = $urandom;
            bus.load_en    = ($urandom_range(0, 9) == 0);
            bus.load_addr  = rnd_addr();
            bus.load_data  = $urandom;
            bus.err_clear  = ($urandom_range(0, 4) == 0);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Unified instruction/data memory responder: the memory end of the CPU's instr_addr/instr_in and data_addr/data_out/data_in/data_rd_wr interface.
- Serves one instruction fetch and one data access per cycle, with 1-cycle registered read latency.
- Provides a bench/boot preload port.
- Flags misaligned and out-of-range accesses through sticky error bits.

Parameters:
BASE_ADDR, 32'h80000000, byte address mapped to word 0
DEPTH_WORDS, 524288, number of 32-bit words (2 MB, covers pc_init 0x80020000 and sp_init 0x80120000)
INSTR_OOR_DATA, 32'h00000000, instr_out value for an out-of-range fetch (NOP)
DATA_OOR_DATA, 32'hDEADBEEF, data_out value for an out-of-range read

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
instr_addr  in  32  fetch byte address (from CPU pc)
instr_out  out  32  fetched word, valid 1 cycle after instr_addr is sampled
data_en  in  1  data access request this cycle
data_rd_wr  in  1  1 = read, 0 = write
data_addr  in  32  data byte address
data_wdata  in  32  write data (CPU data_out)
data_rdata  out  32  read word (CPU data_in), valid 1 cycle after request
load_en  in  1  preload write strobe
load_addr  in  32  preload byte address
load_data  in  32  preload word
err_clear  in  1  clears sticky error flags
err_misaligned  out  1  sticky: access with addr[1:0] != 0
err_range  out  1  sticky: access outside BASE_ADDR .. BASE_ADDR+4*DEPTH_WORDS-1
wr_count  out  32  count of committed CPU data writes, wraps at 2^32

Behaviour:
- Reset low (async):
  - instr_out=0, data_rdata=0, err_misaligned=0, err_range=0, wr_count=0.
  - Memory array is not cleared.
  - A write sampled on the same edge as reset assertion is not committed.
- Index: idx = (addr - BASE_ADDR) >> 2, computed with a 32-bit unsigned subtract.
  - in_range when addr >= BASE_ADDR and idx < DEPTH_WORDS.
  - addr[1:0] is ignored for indexing.
- Fetch (every cycle, no enable):
  - instr_out <= mem[idx(instr_addr)] if in range, else INSTR_OOR_DATA.
  - An out-of-range fetch sets err_range.
  - instr_addr[1:0] != 0 sets err_misaligned; the aligned word is still returned.
- Data read (data_en=1, data_rd_wr=1):
  - data_rdata <= mem[idx] if in range, else DATA_OOR_DATA.
  - data_rdata holds its last value when data_en=0 or on a write.
- Data write (data_en=1, data_rd_wr=0):
  - Committed only if in range, aligned, and load_en=0.
  - Each commit increments wr_count.
  - A misaligned or out-of-range write is dropped and sets the matching error flag.
- Preload:
  - load_en=1 writes load_data to mem[idx(load_addr)] if in range and aligned, else dropped silently (no error flag).
  - Preload has priority over a CPU data write in the same cycle: the CPU write is dropped, with no error flag and no wr_count increment.
  - Fetch and data reads proceed normally during preload.
- Same-cycle write/read collision (write-first):
  - Any committed write (preload or CPU) whose word index equals the fetch or data-read index in that cycle forwards the new data to instr_out and/or data_rdata.
  - A read never returns stale data for a word written on the same edge.
- Error flags:
  - Set on the edge the offending access is sampled.
  - err_clear=1 clears them; a set event on the same edge wins over clear.
- Latency: fixed 1 cycle for both ports; no stall or backpressure; one access per port per cycle.

Test Plan:
- Reset/preload: assert reset mid-run -> all outputs 0 immediately. Release, preload 0x80020000=0x27BDFFF8 and 0x80020004=0x03E00008, drive instr_addr=0x80020000 then 0x80020004 -> instr_out 0x27BDFFF8, then 0x03E00008, each 1 cycle late.
- Store/load: write 0x12345678 to 0x8011FFF8, read it next cycle -> data_rdata=0x12345678, wr_count=1.
- Write-first forwarding: write 0xCAFEF00D to 0x80020008 while instr_addr=0x80020008 and a data read of the same address in the same cycle -> both instr_out and data_rdata =0xCAFEF00D on the next cycle.
- Boundary/errors:
  - Read 0x7FFFFFFC -> data_rdata=0xDEADBEEF, err_range=1.
  - Fetch 0x80200000 -> instr_out=0, err_range=1.
  - Write to 0x80100002 -> memory unchanged, err_misaligned=1, wr_count unchanged.
  - err_clear together with a new error on the same edge -> flag stays 1.
- Preload priority: load_en and a CPU write to different addresses in the same cycle -> only the preload word changes, wr_count unchanged.
